// File: rtl/voice_allocator_if.sv
// -----------------------------------------------------------------------------
// voice_allocator_if
//
// Note-event handshake between the keyboard event source and the voice
// allocator. One event is transferred on a cycle where ev_valid and
// ev_ready are both high.
//
//   ev_valid  source -> allocator  note event present
//   ev_ready  allocator -> source  allocator can accept an event
//   ev_on     source -> allocator  1 = note-on, 0 = note-off
//   ev_note   source -> allocator  note identifier (NOTE_W bits)
//   ev_freq   source -> allocator  frequency word for note-on (FREQ_W bits)
//
// Modports: master = event source, slave = allocator.
// -----------------------------------------------------------------------------
interface voice_allocator_if #(
    parameter int NOTE_W = 8,
    parameter int FREQ_W = 32
);
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_on;
    logic [NOTE_W-1:0] ev_note;
    logic [FREQ_W-1:0] ev_freq;

    modport master (
        output ev_valid,
        output ev_on,
        output ev_note,
        output ev_freq,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_on,
        input  ev_note,
        input  ev_freq,
        output ev_ready
    );
endinterface

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//
// Polyphonic note-to-voice allocator with per-voice linear attack/release
// envelopes. Accepts one note event at a time, scans every voice slot (one
// per cycle) to pick a target, then writes that slot in a single commit
// cycle. An independent envelope engine steps every voice on each tick.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   ev             note-event handshake (voice_allocator_if.slave)
//   tick           single-cycle envelope update strobe
//   frequencies    per-voice frequency words, voice i at [i*FREQ_W +: FREQ_W]
//   voice_volumes  per-voice volumes, voice i at [i*VOL_W +: VOL_W]
//   active         bit i set while voice i is not OFF
// -----------------------------------------------------------------------------
module voice_allocator #(
    parameter int               NUM_VOICES   = 8,
    parameter int               NOTE_W       = 8,
    parameter int               FREQ_W       = 32,
    parameter int               VOL_W        = 16,
    parameter logic [VOL_W-1:0] VOL_MAX      = 16'hFFFF,
    parameter logic [VOL_W-1:0] ATTACK_STEP  = 16'h1000,
    parameter logic [VOL_W-1:0] RELEASE_STEP = 16'h0800
) (
    input  logic                         clk,
    input  logic                         reset_n,
    voice_allocator_if.slave             ev,
    input  logic                         tick,
    output logic [NUM_VOICES*FREQ_W-1:0] frequencies,
    output logic [NUM_VOICES*VOL_W-1:0]  voice_volumes,
    output logic [NUM_VOICES-1:0]        active
);

    localparam int               IDX_W    = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2
    } fsm_t;

    typedef enum logic [1:0] {
        V_OFF     = 2'd0,
        V_ATTACK  = 2'd1,
        V_SUSTAIN = 2'd2,
        V_RELEASE = 2'd3
    } vstate_t;

    // Saturating envelope arithmetic, done one bit wider than the volume.
    function automatic logic [VOL_W-1:0] sat_attack(input logic [VOL_W-1:0] vol);
        logic [VOL_W:0] sum;
        sum = {1'b0, vol} + {1'b0, ATTACK_STEP};
        if (sum > {1'b0, VOL_MAX})
            return VOL_MAX;
        return sum[VOL_W-1:0];
    endfunction

    function automatic logic [VOL_W-1:0] sat_release(input logic [VOL_W-1:0] vol);
        logic [VOL_W:0] diff;
        diff = {1'b0, vol} - {1'b0, RELEASE_STEP};
        // Borrow out of the top bit means the subtraction went below zero.
        if (diff[VOL_W])
            return '0;
        return diff[VOL_W-1:0];
    endfunction

    // Control state
    fsm_t              r_state;
    fsm_t              w_state_nxt;
    logic [IDX_W-1:0]  r_scan_idx;
    logic              r_ev_on;
    logic [NOTE_W-1:0] r_ev_note;
    logic [FREQ_W-1:0] r_ev_freq;
    logic              r_hit_found;
    logic [IDX_W-1:0]  r_hit_idx;
    logic              r_off_found;
    logic [IDX_W-1:0]  r_off_idx;
    logic              r_rel_found;
    logic [IDX_W-1:0]  r_rel_idx;
    logic [IDX_W-1:0]  r_steal_ptr;
    logic              w_accept;

    // Per-voice state
    vstate_t           r_vstate [NUM_VOICES];
    logic [NOTE_W-1:0] r_note   [NUM_VOICES];
    logic [FREQ_W-1:0] r_freq   [NUM_VOICES];
    logic [VOL_W-1:0]  r_vol    [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_active;

    vstate_t           w_vstate_nxt [NUM_VOICES];
    logic [NOTE_W-1:0] w_note_nxt   [NUM_VOICES];
    logic [FREQ_W-1:0] w_freq_nxt   [NUM_VOICES];
    logic [VOL_W-1:0]  w_vol_nxt    [NUM_VOICES];

    // Commit decision
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_wr_fresh;
    logic              w_wr_retrig;
    logic              w_wr_release;
    logic              w_steal;

    assign w_accept    = (r_state == S_IDLE) && ev.ev_valid;
    assign ev.ev_ready = (r_state == S_IDLE);

    // ---- Control FSM: state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (ev.ev_valid) w_state_nxt = S_SCAN;
            S_SCAN:   if (r_scan_idx == LAST_IDX) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ---- Event latch and scan: one voice examined per SCAN cycle ----
    // Voices are visited in ascending order, so the first candidate of each
    // kind that is recorded is the lowest-index one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_idx  <= '0;
            r_ev_on     <= 1'b0;
            r_ev_note   <= '0;
            r_ev_freq   <= '0;
            r_hit_found <= 1'b0;
            r_hit_idx   <= '0;
            r_off_found <= 1'b0;
            r_off_idx   <= '0;
            r_rel_found <= 1'b0;
            r_rel_idx   <= '0;
            r_steal_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_scan_idx  <= '0;
                r_ev_on     <= ev.ev_on;
                r_ev_note   <= ev.ev_note;
                r_ev_freq   <= ev.ev_freq;
                r_hit_found <= 1'b0;
                r_off_found <= 1'b0;
                r_rel_found <= 1'b0;
            end
            if (r_state == S_SCAN) begin
                r_scan_idx <= r_scan_idx + IDX_W'(1);
                if (!r_hit_found && r_note[r_scan_idx] == r_ev_note &&
                    (r_vstate[r_scan_idx] == V_ATTACK ||
                     r_vstate[r_scan_idx] == V_SUSTAIN)) begin
                    r_hit_found <= 1'b1;
                    r_hit_idx   <= r_scan_idx;
                end
                if (!r_off_found && r_vstate[r_scan_idx] == V_OFF) begin
                    r_off_found <= 1'b1;
                    r_off_idx   <= r_scan_idx;
                end
                if (!r_rel_found && r_vstate[r_scan_idx] == V_RELEASE) begin
                    r_rel_found <= 1'b1;
                    r_rel_idx   <= r_scan_idx;
                end
            end
            if (w_steal) begin
                if (r_steal_ptr == LAST_IDX)
                    r_steal_ptr <= '0;
                else
                    r_steal_ptr <= r_steal_ptr + IDX_W'(1);
            end
        end
    end

    // ---- Commit: pick the target voice from the scan results ----
    always_comb begin
        w_wr_en      = 1'b0;
        w_wr_idx     = '0;
        w_wr_fresh   = 1'b0;
        w_wr_retrig  = 1'b0;
        w_wr_release = 1'b0;
        w_steal      = 1'b0;
        if (r_state == S_COMMIT) begin
            if (r_ev_on) begin
                w_wr_en = 1'b1;
                if (r_hit_found) begin
                    w_wr_idx    = r_hit_idx;
                    w_wr_retrig = 1'b1;
                end else if (r_off_found) begin
                    w_wr_idx   = r_off_idx;
                    w_wr_fresh = 1'b1;
                end else if (r_rel_found) begin
                    w_wr_idx   = r_rel_idx;
                    w_wr_fresh = 1'b1;
                end else begin
                    w_wr_idx   = r_steal_ptr;
                    w_wr_fresh = 1'b1;
                    w_steal    = 1'b1;
                end
            end else if (r_hit_found) begin
                // Note-off with no sounding match is simply dropped.
                w_wr_en      = 1'b1;
                w_wr_idx     = r_hit_idx;
                w_wr_release = 1'b1;
            end
        end
    end

    // ---- Voice next-state: commit write wins over the envelope step ----
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_vstate_nxt[i] = r_vstate[i];
            w_note_nxt[i]   = r_note[i];
            w_freq_nxt[i]   = r_freq[i];
            w_vol_nxt[i]    = r_vol[i];
            if (w_wr_en && w_wr_idx == IDX_W'(i)) begin
                if (w_wr_fresh) begin
                    w_note_nxt[i]   = r_ev_note;
                    w_freq_nxt[i]   = r_ev_freq;
                    w_vol_nxt[i]    = '0;
                    w_vstate_nxt[i] = V_ATTACK;
                end
                if (w_wr_retrig) begin
                    w_freq_nxt[i]   = r_ev_freq;
                    w_vstate_nxt[i] = V_ATTACK;
                end
                if (w_wr_release)
                    w_vstate_nxt[i] = V_RELEASE;
            end else if (tick) begin
                case (r_vstate[i])
                    V_ATTACK: begin
                        w_vol_nxt[i] = sat_attack(r_vol[i]);
                        if (w_vol_nxt[i] == VOL_MAX)
                            w_vstate_nxt[i] = V_SUSTAIN;
                    end
                    V_RELEASE: begin
                        w_vol_nxt[i] = sat_release(r_vol[i]);
                        if (w_vol_nxt[i] == '0)
                            w_vstate_nxt[i] = V_OFF;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---- Voice registers ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_vstate[i] <= V_OFF;
                r_note[i]   <= '0;
                r_freq[i]   <= '0;
                r_vol[i]    <= '0;
            end
            r_active <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_vstate[i] <= w_vstate_nxt[i];
                r_note[i]   <= w_note_nxt[i];
                r_freq[i]   <= w_freq_nxt[i];
                r_vol[i]    <= w_vol_nxt[i];
                // Registered alongside the state so it changes on the same edge.
                r_active[i] <= (w_vstate_nxt[i] != V_OFF);
            end
        end
    end

    always_comb begin
        frequencies   = '0;
        voice_volumes = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            frequencies[i*FREQ_W +: FREQ_W] = r_freq[i];
            voice_volumes[i*VOL_W +: VOL_W] = r_vol[i];
        end
    end

    assign active = r_active;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

    localparam int NV = 8;
    localparam int NW = 8;
    localparam int FW = 32;
    localparam int VW = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              tick;
    logic [NV*FW-1:0]  frequencies;
    logic [NV*VW-1:0]  voice_volumes;
    logic [NV-1:0]     active;

    int checks   = 0;
    int failures = 0;

    voice_allocator_if #(.NOTE_W(NW), .FREQ_W(FW)) evif ();

    voice_allocator #(
        .NUM_VOICES(NV), .NOTE_W(NW), .FREQ_W(FW), .VOL_W(VW),
        .VOL_MAX(16'hFFFF), .ATTACK_STEP(16'h1000), .RELEASE_STEP(16'h0800)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ev           (evif),
        .tick         (tick),
        .frequencies  (frequencies),
        .voice_volumes(voice_volumes),
        .active       (active)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] fq(input int i);
        return frequencies[i*FW +: FW];
    endfunction

    function automatic logic [VW-1:0] vl(input int i);
        return voice_volumes[i*VW +: VW];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one event and return #1 after its commit edge.
    task automatic send(input logic on, input logic [NW-1:0] note,
                        input logic [FW-1:0] freq, input bit tick_at_commit);
        int n;
        n = 0;
        while (evif.ev_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("ready_timeout", evif.ev_ready, 1);
        evif.ev_valid = 1'b1;
        evif.ev_on    = on;
        evif.ev_note  = note;
        evif.ev_freq  = freq;
        @(posedge clk); #1;
        evif.ev_valid = 1'b0;
        evif.ev_on    = ~on;
        evif.ev_note  = 8'hAA;
        evif.ev_freq  = 32'hDEAD_BEEF;
        repeat (NV) @(posedge clk);
        #1;
        chk("ready_busy_before_commit", evif.ev_ready, 0);
        if (tick_at_commit) tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(posedge clk); #1;
            tick = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        tick          = 1'b0;
        evif.ev_valid = 1'b0;
        evif.ev_on    = 1'b0;
        evif.ev_note  = '0;
        evif.ev_freq  = '0;
        #12;
        chk("rst_ready", evif.ev_ready, 1);
        chk("rst_active", active, 0);
        chk("rst_freqs", |frequencies, 0);
        chk("rst_vols", |voice_volumes, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single note-on, attack to sustain
        send(1'b1, 8'h3C, 32'h0000_1234, 1'b0);
        chk("on_freq0", fq(0), 32'h1234);
        chk("on_active", active, 8'h01);
        chk("on_vol0", vl(0), 0);
        chk("on_ready", evif.ev_ready, 1);
        ticks(15);
        chk("attack_15", vl(0), 16'hF000);
        ticks(1);
        chk("attack_16", vl(0), 16'hFFFF);
        ticks(1);
        chk("sustain_hold", vl(0), 16'hFFFF);

        // Note-off, release to zero
        send(1'b0, 8'h3C, 32'h0, 1'b0);
        chk("off_vol0", vl(0), 16'hFFFF);
        ticks(31);
        chk("release_31", vl(0), 16'h07FF);
        chk("release_31_active", active, 8'h01);
        ticks(1);
        chk("release_32", vl(0), 16'h0000);
        chk("release_32_active", active, 8'h00);
        chk("release_freq_hold", fq(0), 32'h1234);

        // Fill all voices, then steal
        for (int i = 0; i < NV; i++)
            send(1'b1, NW'(8'h10 + i), FW'(32'h100 + i), 1'b0);
        chk("fill_active", active, 8'hFF);
        chk("fill_freq0", fq(0), 32'h100);
        chk("fill_freq7", fq(7), 32'h107);
        ticks(1);
        chk("fill_vol3", vl(3), 16'h1000);
        send(1'b1, 8'h20, 32'h999, 1'b0);
        chk("steal0_freq", fq(0), 32'h999);
        chk("steal0_vol", vl(0), 0);
        chk("steal0_vol1", vl(1), 16'h1000);
        send(1'b1, 8'h21, 32'h888, 1'b0);
        chk("steal1_freq", fq(1), 32'h888);
        chk("steal1_vol", vl(1), 0);
        chk("steal1_vol2", vl(2), 16'h1000);
        chk("steal1_freq0", fq(0), 32'h999);
        chk("steal_active", active, 8'hFF);

        // Retrigger
        pulse_reset();
        chk("reset2_active", active, 0);
        chk("reset2_freqs", |frequencies, 0);
        chk("reset2_vols", |voice_volumes, 0);
        chk("reset2_ready", evif.ev_ready, 1);
        send(1'b1, 8'h40, 32'h4000, 1'b0);
        ticks(2);
        chk("retrig_pre_vol", vl(0), 16'h2000);
        send(1'b1, 8'h40, 32'h4001, 1'b0);
        chk("retrig_active", active, 8'h01);
        chk("retrig_vol", vl(0), 16'h2000);
        chk("retrig_freq", fq(0), 32'h4001);
        chk("retrig_freq1", fq(1), 0);
        ticks(1);
        chk("retrig_attack", vl(0), 16'h3000);

        // Note-off for an unplayed note
        send(1'b0, 8'h7F, 32'h0, 1'b0);
        chk("drop_active", active, 8'h01);
        chk("drop_vol", vl(0), 16'h3000);
        chk("drop_freq", fq(0), 32'h4001);
        chk("drop_ready", evif.ev_ready, 1);

        // Tick coinciding with commit
        pulse_reset();
        send(1'b1, 8'h50, 32'h5000, 1'b0);
        ticks(1);
        send(1'b0, 8'h50, 32'h0, 1'b0);
        send(1'b1, 8'h51, 32'h5100, 1'b0);
        chk("setup_v1_freq", fq(1), 32'h5100);
        ticks(2);
        chk("setup_active", active, 8'h02);
        chk("setup_v1_vol", vl(1), 16'h2000);
        send(1'b1, 8'h52, 32'h5200, 1'b1);
        chk("tc_v0_vol", vl(0), 0);
        chk("tc_v0_freq", fq(0), 32'h5200);
        chk("tc_v1_vol", vl(1), 16'h3000);
        chk("tc_active", active, 8'h03);
        ticks(1);
        chk("tc_after_v0", vl(0), 16'h1000);
        chk("tc_after_v1", vl(1), 16'h4000);

        // Reset mid-scan
        evif.ev_valid = 1'b1;
        evif.ev_on    = 1'b1;
        evif.ev_note  = 8'h53;
        evif.ev_freq  = 32'h5300;
        @(posedge clk); #1;
        evif.ev_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midscan_busy", evif.ev_ready, 0);
        reset_n = 1'b0;
        #1;
        chk("midscan_rst_active", active, 0);
        chk("midscan_rst_freqs", |frequencies, 0);
        chk("midscan_rst_vols", |voice_volumes, 0);
        chk("midscan_rst_ready", evif.ev_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("midscan_no_commit_active", active, 0);
        chk("midscan_no_commit_freqs", |frequencies, 0);
        chk("midscan_ready", evif.ev_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic note-to-voice allocator with per-voice linear attack/release envelopes. It sits between the PS/2 keyboard decoder and the synthesizer, and drives the synthesizer's per-voice `frequencies` and `voice_volumes` buses. The keyboard block is reduced to an event source. It generalises the fixed 8-voice, gate-only mapping to a parametrised voice count, with the following additions:
- retrigger of a note that is already sounding,
- voice stealing when all voices are busy,
- an envelope engine driven by a tick strobe.

## Interface
Parameters:
- NUM_VOICES, 8, number of voice slots (≥2)
- NOTE_W, 8, note/key-code width
- FREQ_W, 32, frequency word width (passed through unchanged)
- VOL_W, 16, volume width per voice
- VOL_MAX, 16'hFFFF, sustain level
- ATTACK_STEP, 16'h1000, volume increment per tick in attack
- RELEASE_STEP, 16'h0800, volume decrement per tick in release

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ev_valid  in  1  note event present
- ev_ready  out  1  allocator can accept an event
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  NOTE_W  note identifier
- ev_freq  in  FREQ_W  frequency word for note-on (ignored for note-off)
- tick  in  1  single-cycle envelope update strobe
- frequencies  out  NUM_VOICES*FREQ_W  packed; voice i at [i*FREQ_W +: FREQ_W]
- voice_volumes  out  NUM_VOICES*VOL_W  packed, same layout
- active  out  NUM_VOICES  bit i = voice i not OFF

## Operation
- Control FSM states:
  - IDLE: `ev_ready` = 1.
  - SCAN: visits voice 0..NUM_VOICES-1, one per cycle.
  - COMMIT: writes the chosen voice.
  - Transitions: IDLE→SCAN on `ev_valid & ev_ready`; SCAN→COMMIT after the last voice; COMMIT→IDLE.
- `ev_on`, `ev_note` and `ev_freq` are latched on acceptance, so inputs may change afterwards.
- Per-voice state is OFF / ATTACK / SUSTAIN / RELEASE. Each voice stores a note, a frequency and a volume.
- Note-on selection, in priority order:
  1. Lowest-index voice whose note matches and whose state is ATTACK or SUSTAIN (retrigger): state→ATTACK, volume kept, frequency rewritten.
  2. Otherwise the lowest-index OFF voice: note and frequency set, volume←0, state→ATTACK.
  3. Otherwise the lowest-index RELEASE voice, treated as in rule 2.
  4. Otherwise steal the voice at `steal_ptr`, treated as in rule 2. `steal_ptr` then increments modulo NUM_VOICES.
- Note-off: the lowest-index voice with a matching note in ATTACK or SUSTAIN goes to RELEASE. With no match the event is dropped and nothing changes.
- Envelope, applied to all voices in parallel on a cycle with `tick` = 1:
  - ATTACK: vol = min(vol+ATTACK_STEP, VOL_MAX); when the result equals VOL_MAX, state→SUSTAIN.
  - RELEASE: vol = max(vol−RELEASE_STEP, 0); when the result equals 0, state→OFF.
  - OFF and SUSTAIN: no change.
  - Arithmetic is done at VOL_W+1 bits before saturating.
- `frequencies` holds its value through RELEASE and OFF until the voice is reassigned.

## Timing
- Reset values:
  - FSM = IDLE, so `ev_ready` = 1 during and after reset.
  - All voices OFF, volume 0, frequency 0, note 0.
  - `steal_ptr` = 0.
  - `active` = 0.
- Acceptance happens at edge T. SCAN occupies edges T+1..T+NUM_VOICES, COMMIT is at edge T+NUM_VOICES+1, and voice registers and outputs change at that edge.
- `ev_ready` rises after edge T+NUM_VOICES+1. Throughput is one event per NUM_VOICES+2 cycles.
- All outputs are registered. `ev_ready` is decoded from the FSM state.
- `tick` during SCAN: the envelope still updates, and the scan reads live state.
- `tick` coinciding with COMMIT:
  - The committed voice takes the COMMIT write, and its envelope step is skipped for that tick.
  - All other voices step normally.
- Releasing `reset_n` mid-scan abandons the event; no partial commit occurs.
- `ev_valid` while `ev_ready` = 0 is ignored. The source holds the event until the handshake completes.

## Test plan
- Reset, then note-on (note 8'h3C, freq 32'h0000_1234): after NUM_VOICES+2 cycles voice 0 has freq 32'h1234, `active` = 8'h01. After 16 ticks, volume = 16'hFFFF and state is SUSTAIN (15th tick gives 16'hF000).
- Note-off 8'h3C after sustain: each tick subtracts 16'h0800; the 32nd tick gives volume 0, and bit 0 of `active` clears on that same edge.
- 8 distinct note-ons fill voices 0..7 (`active` = 8'hFF). A 9th note-on steals voice 0 (volume 0, new freq); a 10th steals voice 1.
- Note-on 8'h40 twice: the second event retriggers the same voice. No second voice goes active; the volume is unchanged at commit and the state is ATTACK.
- Note-off for an unplayed note 8'h7F: all outputs are unchanged, and `ev_ready` returns after NUM_VOICES+2 cycles.
- `tick` asserted on the COMMIT edge with voice 1 in ATTACK at 16'h2000 while voice 0 is committed: voice 1 → 16'h3000, voice 0 volume = 0. Then `reset_n` pulsed low mid-scan: all outputs are 0 and `ev_ready` = 1.
